// File: rtl/instr_mem_loader.sv
// Instruction-memory loader: writer side of the instruction RAM read by the fetch stage.
// Accepts a byte stream over valid/ready, packs four bytes into a 32-bit word, and writes
// each word to consecutive word addresses. The CPU is held stalled until the END_WORD
// terminator has been written.
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_i          asynchronous active-high reset
//   start_i        begin a load (honoured in idle, done and error)
//   byte_in_i      stream byte
//   byte_valid_i   byte_in_i is valid
//   byte_ready_o   loader accepts a byte this cycle
//   wr_en_o        RAM write strobe, one cycle per word
//   wr_addr_o      RAM word address
//   wr_data_o      assembled instruction word
//   cpu_stall_o    PC stall; low only once the load is complete
//   done_o         terminator written
//   overflow_o     DEPTH words written without a terminator
//   word_count_o   words written in the current load, including the terminator
module instr_mem_loader #(
  parameter int unsigned DEPTH      = 512,
  parameter int unsigned ADDR_W     = 9,
  parameter bit          BIG_ENDIAN = 1'b1,
  parameter logic [31:0] END_WORD   = 32'hFFFF_FFFF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [7:0]        byte_in_i,
  input  logic              byte_valid_i,
  output logic              byte_ready_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [31:0]       wr_data_o,
  output logic              cpu_stall_o,
  output logic              done_o,
  output logic              overflow_o,
  output logic [ADDR_W:0]   word_count_o
);

  typedef enum logic [2:0] {StIdle, StRecv, StWrite, StDone, StError} state_e;

  localparam logic [ADDR_W:0] DepthCnt = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] CntOne   = (ADDR_W + 1)'(1);

  state_e            state_q, state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       asm_q, asm_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
  logic [31:0]       asm_next;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      wr_data_q  <= '0;
      wr_addr_q  <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      wr_data_q  <= wr_data_d;
      wr_addr_q  <= wr_addr_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    wr_data_d  = wr_data_q;
    wr_addr_d  = wr_addr_q;
    word_cnt_d = word_cnt_q;
    // First byte of a word ends up in the MSBs (big endian) or LSBs (little endian).
    asm_next   = BIG_ENDIAN ? {asm_q[23:0], byte_in_i} : {byte_in_i, asm_q[31:8]};

    unique case (state_q)
      StIdle, StDone, StError: begin
        if (start_i) begin
          state_d    = StRecv;
          word_cnt_d = '0;
          wr_addr_d  = '0;
          byte_cnt_d = '0;
          asm_d      = '0;
        end
      end
      StRecv: begin
        if (byte_valid_i) begin
          asm_d      = asm_next;
          byte_cnt_d = byte_cnt_q + 2'd1;  // wraps to 0 on the 4th byte
          if (byte_cnt_q == 2'd3) begin
            // Latch the write address/data now so they stay stable after the strobe.
            state_d   = StWrite;
            wr_data_d = asm_next;
            wr_addr_d = word_cnt_q[ADDR_W-1:0];
          end
        end
      end
      StWrite: begin
        if (word_cnt_q != DepthCnt) begin
          word_cnt_d = word_cnt_q + CntOne;
        end
        // Terminator takes priority even when it lands in the last RAM slot.
        if (wr_data_q == END_WORD) begin
          state_d = StDone;
        end else if (word_cnt_q + CntOne == DepthCnt) begin
          state_d = StError;
        end else begin
          state_d = StRecv;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign byte_ready_o = (state_q == StRecv);
  assign wr_en_o      = (state_q == StWrite);
  assign wr_addr_o    = wr_addr_q;
  assign wr_data_o    = wr_data_q;
  assign cpu_stall_o  = (state_q != StDone);
  assign done_o       = (state_q == StDone);
  assign overflow_o   = (state_q == StError);
  assign word_count_o = word_cnt_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader. Three instances: A (DEPTH 512, big endian), B (DEPTH 4,
// big endian) and C (DEPTH 512, little endian). Expected RAM writes come from a model
// that chops the byte stream into 4-byte words and applies the stop rules.
module tb_instr_mem_loader;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk, rst;
  logic        start_a, start_b, start_c;
  logic [7:0]  byte_in;
  logic        byte_valid;

  logic        rdy_a, wen_a, stall_a, done_a, ovf_a;
  logic [8:0]  addr_a;
  logic [31:0] data_a;
  logic [9:0]  wc_a;
  logic        rdy_b, wen_b, stall_b, done_b, ovf_b;
  logic [1:0]  addr_b;
  logic [31:0] data_b;
  logic [2:0]  wc_b;
  logic        rdy_c, wen_c, stall_c, done_c, ovf_c;
  logic [8:0]  addr_c;
  logic [31:0] data_c;
  logic [9:0]  wc_c;

  int          n_vec = 0;
  int          n_err = 0;
  int          sel = 0;
  int          dbl = 0;
  logic        wen_a_p, wen_b_p, wen_c_p;
  logic        ready_sel, done_sel, ovf_sel, stall_sel;
  int unsigned wc_sel;

  logic [7:0]  stim_q[$];
  wr_t         exp_q[$];
  wr_t         cap_a[$], cap_b[$], cap_c[$];
  bit          exp_done, exp_ovf;

  instr_mem_loader u_a (
    .clk_i(clk), .rst_i(rst), .start_i(start_a), .byte_in_i(byte_in),
    .byte_valid_i(byte_valid), .byte_ready_o(rdy_a), .wr_en_o(wen_a), .wr_addr_o(addr_a),
    .wr_data_o(data_a), .cpu_stall_o(stall_a), .done_o(done_a), .overflow_o(ovf_a),
    .word_count_o(wc_a)
  );

  instr_mem_loader #(.DEPTH(4), .ADDR_W(2)) u_b (
    .clk_i(clk), .rst_i(rst), .start_i(start_b), .byte_in_i(byte_in),
    .byte_valid_i(byte_valid), .byte_ready_o(rdy_b), .wr_en_o(wen_b), .wr_addr_o(addr_b),
    .wr_data_o(data_b), .cpu_stall_o(stall_b), .done_o(done_b), .overflow_o(ovf_b),
    .word_count_o(wc_b)
  );

  instr_mem_loader #(.BIG_ENDIAN(1'b0)) u_c (
    .clk_i(clk), .rst_i(rst), .start_i(start_c), .byte_in_i(byte_in),
    .byte_valid_i(byte_valid), .byte_ready_o(rdy_c), .wr_en_o(wen_c), .wr_addr_o(addr_c),
    .wr_data_o(data_c), .cpu_stall_o(stall_c), .done_o(done_c), .overflow_o(ovf_c),
    .word_count_o(wc_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    ready_sel = rdy_a;
    done_sel  = done_a;
    ovf_sel   = ovf_a;
    stall_sel = stall_a;
    wc_sel    = 32'(wc_a);
    if (sel == 1) begin
      ready_sel = rdy_b;
      done_sel  = done_b;
      ovf_sel   = ovf_b;
      stall_sel = stall_b;
      wc_sel    = 32'(wc_b);
    end else if (sel == 2) begin
      ready_sel = rdy_c;
      done_sel  = done_c;
      ovf_sel   = ovf_c;
      stall_sel = stall_c;
      wc_sel    = 32'(wc_c);
    end
  end

  // Write monitor: records every strobe and counts strobes longer than one cycle.
  always @(negedge clk) begin
    if (wen_a) cap_a.push_back({32'(addr_a), data_a});
    if (wen_b) cap_b.push_back({32'(addr_b), data_b});
    if (wen_c) cap_c.push_back({32'(addr_c), data_c});
    if ((wen_a && wen_a_p) || (wen_b && wen_b_p) || (wen_c && wen_c_p)) dbl <= dbl + 1;
    wen_a_p <= wen_a;
    wen_b_p <= wen_b;
    wen_c_p <= wen_c;
  end

  // Reference: every 4 stream bytes form one word written at the next address; the load
  // stops after the terminator or once DEPTH words are written.
  task automatic build_model(input int s);
    int          depth;
    logic [31:0] w;
    depth    = (s == 1) ? 4 : 512;
    exp_done = 1'b0;
    exp_ovf  = 1'b0;
    exp_q.delete();
    for (int i = 0; i + 3 < stim_q.size(); i += 4) begin
      if (exp_done || exp_ovf) break;
      if (s != 2) w = {stim_q[i], stim_q[i+1], stim_q[i+2], stim_q[i+3]};
      else        w = {stim_q[i+3], stim_q[i+2], stim_q[i+1], stim_q[i]};
      exp_q.push_back({32'(exp_q.size()), w});
      if (w == 32'hFFFF_FFFF)        exp_done = 1'b1;
      else if (exp_q.size() == depth) exp_ovf = 1'b1;
    end
  endtask

  task automatic pulse_start(input int s);
    if (s == 0) start_a = 1'b1;
    if (s == 1) start_b = 1'b1;
    if (s == 2) start_c = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
  endtask

  // mode 0: back-to-back, 1: valid toggles every cycle, 2: random gaps
  task automatic drive_stream(input int mode);
    int tmo;
    bit acc;
    for (int i = 0; i < stim_q.size(); i++) begin
      if (mode == 2 && $urandom_range(0, 2) == 0) begin
        byte_valid = 1'b0;
        @(posedge clk); #1;
      end
      byte_in    = stim_q[i];
      byte_valid = 1'b1;
      tmo        = 0;
      forever begin
        @(negedge clk);
        acc = ready_sel;
        @(posedge clk); #1;
        if (acc) break;
        tmo++;
        if (tmo > 20) begin
          n_vec++;
          n_err++;
          $display("FAIL handshake_timeout byte %0d: byte_ready stayed %b, required 1", i,
                   ready_sel);
          byte_valid = 1'b0;
          return;
        end
      end
      if (mode == 1) begin
        byte_valid = 1'b0;
        byte_in    = 8'($urandom);
        @(posedge clk); #1;
      end
    end
    byte_valid = 1'b0;
  endtask

  // Scenario runner: drives stim_q into instance s and compares the writes and end state.
  task automatic do_load(input string name, input int s, input int mode, input bit do_start);
    wr_t got[$];
    sel = s;
    build_model(s);
    cap_a.delete();
    cap_b.delete();
    cap_c.delete();
    if (do_start) pulse_start(s);
    drive_stream(mode);
    repeat (2) @(posedge clk);
    #1;
    if (s == 0)      got = cap_a;
    else if (s == 1) got = cap_b;
    else             got = cap_c;
    n_vec++;
    if (got.size() !== exp_q.size()) begin
      n_err++;
      $display("FAIL %s write_count: got %0d, required %0d", name, got.size(), exp_q.size());
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (got[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL %s write[%0d]: got %h@%0d, required %h@%0d", name, i, got[i].data,
                 got[i].addr, exp_q[i].data, exp_q[i].addr);
      end
    end
    n_vec++;
    if (done_sel !== exp_done || ovf_sel !== exp_ovf || stall_sel !== !exp_done) begin
      n_err++;
      $display("FAIL %s status: done/ovf/stall got %b%b%b, required %b%b%b", name, done_sel,
               ovf_sel, stall_sel, exp_done, exp_ovf, !exp_done);
    end
    n_vec++;
    if (wc_sel !== exp_q.size()) begin
      n_err++;
      $display("FAIL %s word_count: got %0d, required %0d", name, wc_sel, exp_q.size());
    end
  endtask

  task automatic push_rand_word();
    stim_q.push_back(8'($urandom_range(0, 254)));  // never all-FF, so never the terminator
    repeat (3) stim_q.push_back(8'($urandom));
  endtask

  task automatic push_term();
    repeat (4) stim_q.push_back(8'hFF);
  endtask

  task automatic check_reset_outputs(input string name);
    n_vec++;
    if ({rdy_a, wen_a, stall_a, done_a, ovf_a} !== 5'b00100 || addr_a !== 9'd0 ||
        data_a !== 32'd0 || wc_a !== 10'd0) begin
      n_err++;
      $display("FAIL %s: rdy/wen/stall/done/ovf=%b%b%b%b%b addr=%0d data=%h wc=%0d, required 00100 0 0 0",
               name, rdy_a, wen_a, stall_a, done_a, ovf_a, addr_a, data_a, wc_a);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset_a");
    n_vec++;
    if ({stall_b, stall_c, rdy_b, rdy_c, done_b, done_c} !== 6'b110000) begin
      n_err++;
      $display("FAIL reset_bc: stall/rdy/done got %b%b%b%b%b%b, required 110000", stall_b,
               stall_c, rdy_b, rdy_c, done_b, done_c);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("idle_after_reset");
  endtask

  task automatic test_basic();
    stim_q = '{8'h00, 8'h00, 8'h00, 8'h20, 8'h03, 8'hE0, 8'h00, 8'h08,
               8'hFF, 8'hFF, 8'hFF, 8'hFF};
    do_load("basic", 0, 0, 1'b1);
  endtask

  task automatic test_toggle();
    int d0;
    d0 = dbl;
    stim_q = '{8'h00, 8'h00, 8'h00, 8'h20, 8'h03, 8'hE0, 8'h00, 8'h08,
               8'hFF, 8'hFF, 8'hFF, 8'hFF};
    do_load("toggle", 0, 1, 1'b1);
    n_vec++;
    if (dbl !== d0) begin
      n_err++;
      $display("FAIL toggle wr_en_width: %0d multi-cycle strobes, required 0", dbl - d0);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++) begin
      stim_q.delete();
      repeat ($urandom_range(1, 6)) push_rand_word();
      push_term();
      do_load("random", 0, 2, 1'b1);
    end
  endtask

  task automatic test_restart();
    n_vec++;
    if (done_a !== 1'b1) begin
      n_err++;
      $display("FAIL restart precondition done: got %b, required 1", done_a);
    end
    pulse_start(0);
    n_vec++;
    if (done_a !== 1'b0 || stall_a !== 1'b1 || rdy_a !== 1'b1) begin
      n_err++;
      $display("FAIL restart state: done/stall/rdy got %b%b%b, required 011", done_a, stall_a,
               rdy_a);
    end
    stim_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    do_load("restart", 0, 0, 1'b0);
  endtask

  task automatic test_async_reset();
    sel = 0;
    stim_q = '{8'h5A, 8'hC3};
    pulse_start(0);
    drive_stream(0);
    #3;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    stim_q = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    do_load("after_reset", 0, 0, 1'b1);
  endtask

  task automatic test_little_endian();
    stim_q = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    do_load("little", 2, 0, 1'b1);
    stim_q.delete();
    repeat (3) push_rand_word();
    push_term();
    do_load("little_rand", 2, 2, 1'b1);
  endtask

  task automatic test_overflow();
    stim_q.delete();
    repeat (4) push_rand_word();
    do_load("overflow", 1, 2, 1'b1);
    byte_valid = 1'b1;
    byte_in    = 8'h11;
    repeat (4) begin
      @(negedge clk);
      n_vec++;
      if (rdy_b !== 1'b0) begin
        n_err++;
        $display("FAIL overflow byte_ready: got %b, required 0", rdy_b);
      end
    end
    @(posedge clk); #1;
    byte_valid = 1'b0;
    n_vec++;
    if (cap_b.size() !== 4) begin
      n_err++;
      $display("FAIL overflow extra_writes: got %0d writes, required 4", cap_b.size());
    end
    // Terminator in the very last slot must finish the load, not overflow it.
    stim_q.delete();
    repeat (3) push_rand_word();
    push_term();
    do_load("term_last_slot", 1, 0, 1'b1);
  endtask

  initial begin
    rst        = 1'b1;
    start_a    = 1'b0;
    start_b    = 1'b0;
    start_c    = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    test_reset();
    test_basic();
    test_toggle();
    test_random();
    test_restart();
    test_async_reset();
    test_little_endian();
    test_overflow();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
